// File: rtl/reg_writeback_arb.sv
// Register writeback arbiter: LSU beats ALU by default, but an ALU request that
// has been denied for too long is forced through. Also tracks pending writes.
module reg_writeback_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            hazard,
  output logic [31:0]     busy,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam int WW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIM);

  logic [WW-1:0]   wait_cnt;
  logic            starved;
  logic            alu_hs;
  logic            lsu_hs;
  logic            hs;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  // Handshake: a source transfers on a posedge where its valid and ready are
  // both 1; ready never depends on the source's own valid, and at most one
  // source is ready while the other is valid, so transfers are exclusive.
  always_comb begin
    starved   = (wait_cnt == LIM);
    alu_ready = starved | ~lsu_valid;
    lsu_ready = ~starved;
    alu_hs    = alu_valid & alu_ready;
    lsu_hs    = lsu_valid & lsu_ready;
    hs        = alu_hs | lsu_hs;
    sel_rd    = lsu_hs ? lsu_rd : alu_rd;
    sel_data  = lsu_hs ? lsu_data : alu_data;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask[iss_rd] = 1'b1;
    if (rd_we) clr_mask[rd_addr] = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_comb begin
    hazard = ((rs1_addr != 5'd0) && busy[rs1_addr]) ||
             ((rs2_addr != 5'd0) && busy[rs2_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!alu_valid || alu_hs) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIM) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_we   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_we <= hs && (sel_rd != 5'd0);
      if (hs && (sel_rd != 5'd0)) begin
        rd_addr <= sel_rd;
        rd_data <= sel_data;
      end
    end
  end

  // Set is applied after clear so a re-issue on the commit edge keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Randomized and directed bench for reg_writeback_arb against a cycle-level
// reference model plus a writeback scoreboard.
module tb_reg_writeback_arb;

  localparam int XLEN       = 32;
  localparam int STARVE_LIM = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            hazard;
  logic [31:0]     busy;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  reg_writeback_arb #(.XLEN(XLEN), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard(hazard), .busy(busy), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int              m_wait;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [31:0]     m_busy;
  logic [XLEN+4:0] exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    m_wait = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_busy = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_rd_we", rd_we, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
  endtask

  // Checks current outputs against the model, then advances one clock.
  task automatic step();
    logic            starved;
    logic            lsu_win;
    logic            alu_win;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_data;
    logic [31:0]     nb;
    logic [XLEN+4:0] e;
    int              nw;
    #2;
    starved = (m_wait == STARVE_LIM);
    chk("alu_ready", alu_ready, starved || !lsu_valid);
    chk("lsu_ready", lsu_ready, !starved);
    chk("rd_we", rd_we, m_we);
    chk("rd_addr", rd_addr, m_addr);
    chk("rd_data", rd_data, m_data);
    chk("busy", busy, m_busy);
    chk("hazard", hazard, (rs1_addr != 0 && m_busy[rs1_addr]) || (rs2_addr != 0 && m_busy[rs2_addr]));
    if (rd_we === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_write", {rd_addr, rd_data}, e);
      end
    end
    lsu_win = lsu_valid && !starved;
    alu_win = alu_valid && (starved || !lsu_valid);
    nw = (alu_valid && !alu_win) ? ((m_wait + 1 > STARVE_LIM) ? STARVE_LIM : m_wait + 1) : 0;
    nb = m_busy;
    if (m_we) nb[m_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
    w_rd   = lsu_win ? lsu_rd : alu_rd;
    w_data = lsu_win ? lsu_data : alu_data;
    @(posedge clk);
    #1;
    m_wait = nw;
    m_busy = nb;
    m_we   = (lsu_win || alu_win) && (w_rd != 0);
    if (m_we) begin
      m_addr = w_rd;
      m_data = w_data;
      exp_q.push_back({w_rd, w_data});
    end
  endtask

  task automatic peek_ready(input string tag, input logic exp_alu, input logic exp_lsu);
    #1;
    chk({tag, "_alu_ready"}, alu_ready, exp_alu);
    chk({tag, "_lsu_ready"}, lsu_ready, exp_lsu);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // LSU alone writes next cycle
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hDEADBEEF;
    step();
    chk("lsu_only_we", rd_we, 1);
    chk("lsu_only_addr", rd_addr, 5);
    chk("lsu_only_data", rd_data, 32'hDEADBEEF);
    idle();
    step();
    chk("no_hs_we", rd_we, 0);
    chk("no_hs_hold", rd_data, 32'hDEADBEEF);

    // both valid: LSU wins, held ALU follows
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    peek_ready("both", 0, 1);
    step();
    chk("both_addr", rd_addr, 4);
    lsu_valid = 0;
    step();
    chk("alu_follow_addr", rd_addr, 3);
    chk("alu_follow_data", rd_data, 32'h33);
    idle();
    step();

    // starvation: three denials then forced ALU win
    lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h1;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    for (int k = 0; k < STARVE_LIM; k++) begin
      peek_ready("starve_wait", 0, 1);
      step();
    end
    peek_ready("starve_force", 1, 0);
    step();
    alu_valid = 0;
    chk("starve_addr", rd_addr, 7);
    chk("starve_data", rd_data, 32'h77);
    peek_ready("after_force", 0, 1);
    step();
    idle();
    step();

    // hazard tracking
    iss_valid = 1; iss_rd = 9;
    step();
    iss_valid = 0; rs1_addr = 9;
    #1 chk("hazard_set", hazard, 1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    alu_valid = 0;
    chk("hz_commit_we", rd_we, 1);
    #1 chk("hazard_during_we", hazard, 1);
    step();
    chk("hazard_clear", hazard, 0);

    // same-edge set and clear keeps busy
    iss_valid = 1; iss_rd = 9;
    step();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h999;
    step();
    alu_valid = 0;
    iss_valid = 1; iss_rd = 9;
    chk("reissue_we", rd_we, 1);
    step();
    iss_valid = 0;
    chk("reissue_busy9", busy[9], 1);
    step();

    // x0 write is accepted but dropped
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    peek_ready("x0", 1, 1);
    step();
    alu_valid = 0;
    chk("x0_we", rd_we, 0);
    chk("x0_hold", rd_data, 32'h999);

    // asynchronous reset drops an in-flight write and pending bits
    iss_valid = 1; iss_rd = 12;
    lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
    step();
    idle();
    chk("pre_rst_we", rd_we, 1);
    chk("pre_rst_busy12", busy[12], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_we", rd_we, 0);
    chk("async_rst_busy", busy, 0);
    do_reset();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      alu_valid = ($urandom_range(0, 99) < 60);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 70);
      lsu_rd    = 5'($urandom_range(0, 31));
      lsu_data  = $urandom;
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arb.md
REG_WRITEBACK_ARB -- requirements
Module: reg_writeback_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter STARVE_LIM, default 3, meaning consecutive ALU denials before ALU is forced to win.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 The block SHALL have port alu_rd  input  5  ALU destination register index.
REQ-008 The block SHALL have port alu_data  input  XLEN  ALU result.
REQ-009 The block SHALL have port lsu_valid  input  1  load writeback request.
REQ-010 The block SHALL have port lsu_ready  output  1  load request accepted this cycle.
REQ-011 The block SHALL have port lsu_rd  input  5  load destination register index.
REQ-012 The block SHALL have port lsu_data  input  XLEN  load data.
REQ-013 The block SHALL have port iss_valid  input  1  instruction issued with a destination register.
REQ-014 The block SHALL have port iss_rd  input  5  destination index to mark pending.
REQ-015 The block SHALL have port rs1_addr  input  5  source-1 index for hazard query.
REQ-016 The block SHALL have port rs2_addr  input  5  source-2 index for hazard query.
REQ-017 The block SHALL have port hazard  output  1  a queried source has a pending write.
REQ-018 The block SHALL have port busy  output  32  pending-write bitmap, bit i = register i.
REQ-019 The block SHALL have port rd_we  output  1  register-file write enable, registered.
REQ-020 The block SHALL have port rd_addr  output  5  register-file write index, registered.
REQ-021 The block SHALL have port rd_data  output  XLEN  register-file write data, registered.

Function
REQ-022 A handshake SHALL occur on a source when its valid and ready are both 1 at posedge clk; at most one handshake per cycle.
REQ-023 Default priority: lsu_ready = 1 and alu_ready = !lsu_valid, both combinational.
REQ-024 A wait counter SHALL increment (saturating at STARVE_LIM) each cycle alu_valid=1 and alu_ready=0, and clear on ALU handshake or alu_valid=0.
REQ-025 When wait counter == STARVE_LIM: alu_ready = 1, lsu_ready = 0 for that cycle.
REQ-026 On a handshake with rd != 0, rd_we SHALL be 1 with that rd/data on the next cycle for exactly one cycle unless another handshake follows.
REQ-027 A handshake with rd == 0 SHALL complete (ready=1) but rd_we SHALL stay 0; rd_addr/rd_data hold.
REQ-028 With no handshake, rd_we SHALL be 0 next cycle; rd_addr/rd_data hold last value.
REQ-029 busy[i] SHALL set at posedge when iss_valid=1 and iss_rd=i, i != 0.
REQ-030 busy[i] SHALL clear at posedge when rd_we=1 and rd_addr=i (same edge the register file commits).
REQ-031 Simultaneous set and clear of the same index: set wins, busy[i] stays 1.
REQ-032 busy[0] SHALL be constant 0.
REQ-033 hazard = (rs1_addr != 0 && busy[rs1_addr]) || (rs2_addr != 0 && busy[rs2_addr]), combinational.
REQ-034 Writebacks to a non-busy index SHALL still be performed; no error flag.

Reset
REQ-035 While rst_n=0: rd_we=0, rd_addr=0, rd_data=0, busy=0, wait counter=0, independent of clk.
REQ-036 Reset mid-operation SHALL discard the in-flight registered write (rd_we forced 0 immediately) and all pending bits.
REQ-037 The first handshake SHALL be possible on the first posedge after rst_n rises.

Verification
REQ-038 LSU only: lsu_valid=1, lsu_rd=5, lsu_data=0xDEADBEEF -> next cycle rd_we=1, rd_addr=5, rd_data=0xDEADBEEF.
REQ-039 Both valid one cycle (ALU rd=3, LSU rd=4) -> lsu wins, alu_ready=0; with alu held, ALU writes rd=3 the cycle after.
REQ-040 LSU valid continuously, ALU valid rd=7 -> alu_ready=0 for 3 cycles, alu_ready=1 and lsu_ready=0 on the 4th; rd_addr=7 on the 5th.
REQ-041 iss_valid rd=9; rs1_addr=9 -> hazard=1 next cycle; ALU writes rd=9 -> hazard=0 the cycle after rd_we=1.
REQ-042 Same edge: rd_we=1 rd_addr=9 and iss_valid iss_rd=9 -> busy[9] remains 1.
REQ-043 ALU handshake rd=0 data=0x1234 -> rd_we stays 0; rst_n low while rd_we=1 -> rd_we, busy drop to 0 without a clock edge.
